hba_master_arbiter: RTL and testbench

- Round-robin bus arbiter for up to 4 HBA master peripherals.
- Issues a one-hot grant; only the granted master drives its rnw/select/abus/dbus outputs, and all other masters drive zeros.
- This makes the downstream master-OR stage produce a clean bus.
- Enforces one dead cycle between grants, and revokes a grant from a master that stalls without transfer acknowledges.

---
 rtl/hba_master_arbiter.sv | 132 +++++++++++++
 tb/tb_hba_master_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hba_master_arbiter.sv
// Round-robin arbiter for up to four HBA bus masters: registered one-hot grant,
// a forced dead cycle between tenures, and revocation of masters that stall without acks.
module hba_master_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic       hba_clk,
    input  logic       hba_reset,
    input  logic [3:0] hba_mreq,
    input  logic       hba_xferack,
    output logic [3:0] hba_mgrant,
    output logic       hba_bus_busy,
    output logic [1:0] hba_grant_id,
    output logic       hba_arb_timeout,
    output logic [1:0] hba_timeout_id
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [3:0]  VALID_MASK   = 4'((1 << NUM_MASTERS) - 1);
    localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TIMEOUT_LAST = TIMEOUT_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

    state_t      state_q,      state_d;
    logic [3:0]  grant_q,      grant_d;
    logic        busy_q,       busy_d;
    logic [1:0]  grant_id_q,   grant_id_d;
    logic        timeout_q,    timeout_d;
    logic [1:0]  timeout_id_q, timeout_id_d;
    logic [1:0]  ptr_q,        ptr_d;
    logic [3:0]  mask_q,       mask_d;
    logic [15:0] cnt_q,        cnt_d;

    logic [3:0]  eligible;
    logic [1:0]  sel;
    logic        sel_valid;

    assign eligible = hba_mreq & ~mask_q & VALID_MASK;

    // Scan from farthest to nearest so the nearest set bit after the pointer wins.
    always_comb begin
        sel_valid = 1'b0;
        sel       = ptr_q;
        for (int k = 4; k >= 1; k--) begin
            if (eligible[ptr_q + 2'(k)]) begin
                sel_valid = 1'b1;
                sel       = ptr_q + 2'(k);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        grant_id_d   = grant_id_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        timeout_d    = 1'b0;
        timeout_id_d = timeout_id_q;
        mask_d       = mask_q & hba_mreq & VALID_MASK;

        unique case (state_q)
            IDLE: begin
                grant_d = 4'b0000;
                if (sel_valid) begin
                    grant_d    = 4'b0001 << sel;
                    grant_id_d = sel;
                    ptr_d      = sel;
                    cnt_d      = 16'd0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                // A normal release outranks an expiring counter.
                if (!hba_mreq[grant_id_q]) begin
                    grant_d = 4'b0000;
                    state_d = IDLE;
                end else if (hba_xferack) begin
                    cnt_d = 16'd0;
                end else if (TIMEOUT_EN && (cnt_q == TIMEOUT_LAST)) begin
                    grant_d            = 4'b0000;
                    timeout_d          = 1'b1;
                    timeout_id_d       = grant_id_q;
                    mask_d[grant_id_q] = 1'b1;
                    state_d            = IDLE;
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                grant_d = 4'b0000;
                state_d = IDLE;
            end
        endcase

        busy_d = |grant_d;
    end

    always_ff @(posedge hba_clk) begin
        if (hba_reset) begin
            state_q      <= IDLE;
            grant_q      <= 4'b0000;
            busy_q       <= 1'b0;
            grant_id_q   <= 2'd3;
            timeout_q    <= 1'b0;
            timeout_id_q <= 2'd0;
            ptr_q        <= 2'd3;
            mask_q       <= 4'b0000;
            cnt_q        <= 16'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
            grant_id_q   <= grant_id_d;
            timeout_q    <= timeout_d;
            timeout_id_q <= timeout_id_d;
            ptr_q        <= ptr_d;
            mask_q       <= mask_d;
            cnt_q        <= cnt_d;
        end
    end

    assign hba_mgrant      = grant_q;
    assign hba_bus_busy    = busy_q;
    assign hba_grant_id    = grant_id_q;
    assign hba_arb_timeout = timeout_q;
    assign hba_timeout_id  = timeout_id_q;

endmodule

// File: tb/tb_hba_master_arbiter.sv
// Bench for hba_master_arbiter: directed scenarios followed by random traffic, every
// cycle compared against a tenure-level reference model of the arbitration rules.
module tb_hba_master_arbiter;

    localparam int NM = 4;
    localparam int TO = 8;

    logic       hba_clk;
    logic       hba_reset;
    logic [3:0] hba_mreq;
    logic       hba_xferack;
    logic [3:0] hba_mgrant;
    logic       hba_bus_busy;
    logic [1:0] hba_grant_id;
    logic       hba_arb_timeout;
    logic [1:0] hba_timeout_id;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Model state: who owns the bus (-1 = nobody), last winner, cycles since an ack.
    int       m_owner;
    int       m_last;
    int       m_gid;
    int       m_quiet;
    int       m_to_id;
    bit       m_to_pulse;
    bit [3:0] m_blocked;

    hba_master_arbiter #(
        .NUM_MASTERS   (NM),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .hba_clk        (hba_clk),
        .hba_reset      (hba_reset),
        .hba_mreq       (hba_mreq),
        .hba_xferack    (hba_xferack),
        .hba_mgrant     (hba_mgrant),
        .hba_bus_busy   (hba_bus_busy),
        .hba_grant_id   (hba_grant_id),
        .hba_arb_timeout(hba_arb_timeout),
        .hba_timeout_id (hba_timeout_id)
    );

    initial hba_clk = 1'b0;
    always #5 hba_clk = ~hba_clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int pick;
        if (hba_reset) begin
            m_owner    = -1;
            m_last     = 3;
            m_gid      = 3;
            m_quiet    = 0;
            m_to_id    = 0;
            m_to_pulse = 1'b0;
            m_blocked  = 4'b0000;
        end else begin
            m_to_pulse = 1'b0;
            if (m_owner < 0) begin
                pick = -1;
                for (int d = 1; d <= 4 && pick < 0; d++) begin
                    int m;
                    m = (m_last + d) % 4;
                    if (m < NM && hba_mreq[m] && !m_blocked[m]) pick = m;
                end
                if (pick >= 0) begin
                    m_owner = pick;
                    m_last  = pick;
                    m_gid   = pick;
                    m_quiet = 0;
                end
            end else if (!hba_mreq[m_owner]) begin
                m_owner = -1;
            end else begin
                m_quiet = hba_xferack ? 0 : m_quiet + 1;
                if (TO != 0 && m_quiet == TO) begin
                    m_to_pulse         = 1'b1;
                    m_to_id            = m_owner;
                    m_blocked[m_owner] = 1'b1;
                    m_owner            = -1;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (!hba_mreq[i]) m_blocked[i] = 1'b0;
            end
        end
    endtask

    task automatic check_all(input string ctx);
        logic [3:0] exp_grant;
        exp_grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        check_output({ctx, ".mgrant"},     32'(hba_mgrant),      32'(exp_grant));
        check_output({ctx, ".busy"},       32'(hba_bus_busy),    32'(m_owner >= 0));
        check_output({ctx, ".grant_id"},   32'(hba_grant_id),    32'(m_gid));
        check_output({ctx, ".timeout"},    32'(hba_arb_timeout), 32'(m_to_pulse));
        check_output({ctx, ".timeout_id"}, 32'(hba_timeout_id),  32'(m_to_id));
    endtask

    // One clock: the model consumes the same inputs the DUT samples, then both are compared.
    task automatic apply_stimulus(input string ctx);
        @(posedge hba_clk);
        model_step();
        #1;
        check_all(ctx);
    endtask

    initial begin
        int held;
        int order[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};

        m_owner = -1; m_last = 3; m_gid = 3; m_quiet = 0;
        m_to_id = 0;  m_to_pulse = 1'b0; m_blocked = 4'b0000;
        hba_reset = 1'b1; hba_mreq = 4'b0000; hba_xferack = 1'b0;

        apply_stimulus("reset");
        apply_stimulus("reset");
        check_output("reset.grant_id", 32'(hba_grant_id), 32'd3);
        check_output("reset.mgrant",   32'(hba_mgrant),   32'd0);

        hba_reset = 1'b0;
        apply_stimulus("single.idle");
        hba_mreq = 4'b0001;
        apply_stimulus("single.grant");
        check_output("single.first_grant", 32'(hba_mgrant), 32'h1);
        check_output("single.busy",        32'(hba_bus_busy), 32'd1);
        repeat (3) apply_stimulus("single.hold");
        hba_mreq = 4'b0000;
        apply_stimulus("single.release");
        check_output("single.released", 32'(hba_mgrant), 32'h0);

        hba_reset = 1'b1;
        apply_stimulus("rr.reset");
        hba_reset = 1'b0;
        hba_mreq  = 4'b1111;
        held      = 0;
        for (int c = 0; c < 20; c++) begin
            apply_stimulus("rr");
            if (m_owner >= 0) begin
                held++;
                if (held == 1) order.push_back(int'(hba_grant_id));
                if (held == 3) hba_mreq[m_owner] = 1'b0;
            end else begin
                held     = 0;
                hba_mreq = 4'b1111;
            end
        end
        check_output("rr.tenures", 32'(order.size()), 32'd5);
        for (int i = 0; i < 5 && i < order.size(); i++) begin
            check_output($sformatf("rr.order%0d", i), 32'(order[i]), 32'(exp_order[i]));
        end
        hba_mreq = 4'b0000;
        repeat (2) apply_stimulus("rr.drain");

        hba_mreq = 4'b0100;
        apply_stimulus("pre.grant2");
        check_output("pre.grant2", 32'(hba_mgrant), 32'h4);
        hba_mreq = 4'b0101;
        repeat (3) apply_stimulus("pre.hold");
        check_output("pre.no_preempt", 32'(hba_mgrant), 32'h4);
        hba_mreq = 4'b0001;
        apply_stimulus("pre.dead");
        check_output("pre.dead", 32'(hba_mgrant), 32'h0);
        apply_stimulus("pre.handover");
        check_output("pre.handover", 32'(hba_mgrant), 32'h1);
        hba_mreq = 4'b0000;
        repeat (2) apply_stimulus("pre.drain");

        hba_mreq = 4'b0010;
        apply_stimulus("abandon.grant1");
        hba_mreq = 4'b1010;
        repeat (2) apply_stimulus("abandon.blip");
        hba_mreq = 4'b0010;
        apply_stimulus("abandon.blip_gone");
        hba_mreq = 4'b0000;
        repeat (2) apply_stimulus("abandon.idle");
        check_output("abandon.never_granted", 32'(hba_mgrant), 32'h0);

        hba_mreq = 4'b0010;
        for (int i = 0; i < TO; i++) begin
            apply_stimulus("to.stall");
            check_output("to.held", 32'(hba_mgrant), 32'h2);
        end
        apply_stimulus("to.revoke");
        check_output("to.pulse",   32'(hba_arb_timeout), 32'd1);
        check_output("to.id",      32'(hba_timeout_id),  32'd1);
        check_output("to.revoked", 32'(hba_mgrant),      32'h0);
        apply_stimulus("to.after");
        check_output("to.one_pulse", 32'(hba_arb_timeout), 32'd0);
        repeat (3) apply_stimulus("to.masked");
        check_output("to.masked", 32'(hba_mgrant), 32'h0);
        hba_mreq = 4'b0000;
        apply_stimulus("to.drop");
        hba_mreq = 4'b0010;
        apply_stimulus("to.regrant");
        check_output("to.regrant", 32'(hba_mgrant), 32'h2);

        for (int c = 0; c < 100; c++) begin
            hba_xferack = (c % 7 == 6);
            apply_stimulus("ack");
            check_output("ack.no_timeout", 32'(hba_arb_timeout), 32'd0);
        end
        hba_xferack = 1'b0;
        hba_mreq    = 4'b0000;
        apply_stimulus("exp.idle");
        hba_mreq = 4'b0001;
        apply_stimulus("exp.grant");
        repeat (TO - 1) apply_stimulus("exp.stall");
        check_output("exp.still_held", 32'(hba_mgrant), 32'h1);
        hba_mreq = 4'b0000;
        apply_stimulus("exp.release");
        check_output("exp.no_pulse", 32'(hba_arb_timeout), 32'd0);
        check_output("exp.released", 32'(hba_mgrant),      32'h0);
        apply_stimulus("exp.quiet");

        hba_mreq = 4'b1000;
        apply_stimulus("rst.grant3");
        check_output("rst.grant3", 32'(hba_mgrant), 32'h8);
        apply_stimulus("rst.hold");
        hba_reset = 1'b1;
        hba_mreq  = 4'b1010;
        apply_stimulus("rst.mid");
        check_output("rst.mgrant",   32'(hba_mgrant),   32'h0);
        check_output("rst.grant_id", 32'(hba_grant_id), 32'd3);
        hba_reset = 1'b0;
        apply_stimulus("rst.first");
        check_output("rst.first", 32'(hba_mgrant), 32'h2);
        hba_mreq = 4'b0000;
        repeat (2) apply_stimulus("rst.drain");

        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(7) == 0) hba_mreq[i] = ~hba_mreq[i];
            end
            hba_xferack = ($urandom_range(9) == 0);
            hba_reset   = ($urandom_range(249) == 0);
            apply_stimulus("rand");
        end

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
